// File: rtl/alu8_reg.sv
// alu8_reg: registered ALU with one-cycle latency, producing result plus carry/zero/overflow flags.
// Optional feature macro ALU_STICKY_FLAGS_EN adds flags_clr, sticky_carry and sticky_overflow.
module alu8_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic             flags_clr,
  output logic             sticky_carry,
  output logic             sticky_overflow,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_NOT = 3'b110,
    OP_XOR = 3'b111
  } op_e;

  // Same-sign operands producing a result of the opposite sign, applied to every opcode.
  function automatic logic calc_overflow(input logic sign_a, input logic sign_b, input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             zero_s;
  logic             ovf_s;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;

  // Combinational operation and flag evaluation for the current operands.
  always_comb begin
    sum_s   = {1'b0, a} + {1'b0, b};
    res_s   = '0;
    carry_s = 1'b0;
    case (opcode)
      OP_AND:  res_s = a & b;
      OP_OR:   res_s = a | b;
      OP_ADD: begin
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
      end
      OP_SUB:  res_s = a - b;
      OP_SHL:  res_s = a << b;
      OP_SHR:  res_s = a >> b;
      OP_NOT:  res_s = ~a;
      OP_XOR:  res_s = a ^ b;
      default: res_s = '0;
    endcase
    zero_s = (res_s == '0);
    ovf_s  = calc_overflow(a[WIDTH-1], b[WIDTH-1], res_s[WIDTH-1]);
  end

  // Next-state selection: load a new op when valid, otherwise hold result and flags.
  always_comb begin
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d   = res_s;
      carry_d    = carry_s;
      zero_d     = zero_s;
      overflow_d = ovf_s;
    end else begin
      result_d   = result_q;
      carry_d    = carry_q;
      zero_d     = zero_q;
      overflow_d = overflow_q;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;

`ifdef ALU_STICKY_FLAGS_EN
  logic sticky_carry_d, sticky_carry_q;
  logic sticky_overflow_d, sticky_overflow_q;

  // A clear together with a valid op reloads from that op so its flags are never lost.
  always_comb begin
    if (in_valid) begin
      if (flags_clr) begin
        sticky_carry_d    = carry_s;
        sticky_overflow_d = ovf_s;
      end else begin
        sticky_carry_d    = sticky_carry_q | carry_s;
        sticky_overflow_d = sticky_overflow_q | ovf_s;
      end
    end else begin
      if (flags_clr) begin
        sticky_carry_d    = 1'b0;
        sticky_overflow_d = 1'b0;
      end else begin
        sticky_carry_d    = sticky_carry_q;
        sticky_overflow_d = sticky_overflow_q;
      end
    end
  end

  // Sticky flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_carry_q    <= 1'b0;
      sticky_overflow_q <= 1'b0;
    end else begin
      sticky_carry_q    <= sticky_carry_d;
      sticky_overflow_q <= sticky_overflow_d;
    end
  end

  assign sticky_carry    = sticky_carry_q;
  assign sticky_overflow = sticky_overflow_q;
`endif

endmodule

// File: tb/tb_alu8_reg.sv
// Self-checking bench for alu8_reg: a driver pushes reference-model expectations into a queue,
// and a monitor pops and compares them against the registered outputs each cycle.
module tb_alu8_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] opcode;
  logic       flags_clr;
  logic       out_valid;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       overflow;
`ifdef ALU_STICKY_FLAGS_EN
  logic       sticky_carry;
  logic       sticky_overflow;
`endif

  always #5 clk = ~clk;

  alu8_reg #(.WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .a              (a),
    .b              (b),
    .opcode         (opcode),
`ifdef ALU_STICKY_FLAGS_EN
    .flags_clr      (flags_clr),
    .sticky_carry   (sticky_carry),
    .sticky_overflow(sticky_overflow),
`endif
    .out_valid      (out_valid),
    .result         (result),
    .carry          (carry),
    .zero           (zero),
    .overflow       (overflow)
  );

  typedef struct {
    int v;
    int r;
    int c;
    int z;
    int o;
    int sc;
    int so;
  } exp_t;

  exp_t exp_q[$];
  exp_t st;
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;

  // Reference ALU in plain integer arithmetic.
  task automatic ref_op(input int av, input int bv, input int op, output int r, output int c);
    c = 0;
    case (op)
      0: r = av & bv;
      1: r = av | bv;
      2: begin r = (av + bv) % 256; c = ((av + bv) > 255) ? 1 : 0; end
      3: r = (av - bv + 256) % 256;
      4: r = (bv >= 8) ? 0 : ((av * (1 << bv)) % 256);
      5: r = (bv >= 8) ? 0 : (av / (1 << bv));
      6: r = 255 - av;
      default: r = av ^ bv;
    endcase
  endtask

  task automatic drive(input logic r_i, input logic iv, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] op, input logic fc);
    int r, c, o;
    rst = r_i; in_valid = iv; a = av; b = bv; opcode = op; flags_clr = fc;
    @(posedge clk);
    if (r_i) begin
      st = '{0, 0, 0, 0, 0, 0, 0};
    end else if (iv) begin
      ref_op(int'(av), int'(bv), int'(op), r, c);
      o = ((av / 128) == (bv / 128) && (r / 128) != (av / 128)) ? 1 : 0;
      st.v = 1; st.r = r; st.c = c; st.z = (r == 0) ? 1 : 0; st.o = o;
      st.sc = fc ? c : (st.sc | c);
      st.so = fc ? o : (st.so | o);
    end else begin
      st.v = 0;
      if (fc) begin st.sc = 0; st.so = 0; end
    end
    exp_q.push_back(st);
    @(negedge clk);
  endtask

  // Monitor: compare every registered output cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    int ok;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ok = (int'(out_valid) == e.v) && (int'(result) == e.r) && (int'(carry) == e.c) &&
           (int'(zero) == e.z) && (int'(overflow) == e.o);
`ifdef ALU_STICKY_FLAGS_EN
      ok = ok && (int'(sticky_carry) == e.sc) && (int'(sticky_overflow) == e.so);
`endif
      checks++;
      if (ok != 0) passed++;
      else $display("FAIL outputs cycle %0d: got v=%0b r=%02h c=%0b z=%0b o=%0b, need v=%0d r=%02h c=%0d z=%0d o=%0d",
                    cyc, out_valid, result, carry, zero, overflow, e.v, e.r, e.c, e.z, e.o);
    end
  end

  logic [7:0] dir_a  [12] = '{8'd200, 8'd100, 8'd5, 8'd3, 8'h81, 8'h81, 8'h80, 8'h80, 8'h0F, 8'hF0, 8'hF0, 8'hAA};
  logic [7:0] dir_b  [12] = '{8'd100, 8'd100, 8'd5, 8'd5, 8'd1,  8'd9,  8'd7,  8'd8,  8'h20, 8'h0F, 8'h0F, 8'hFF};
  logic [2:0] dir_op [12] = '{3'd2,   3'd2,   3'd3, 3'd3, 3'd4,  3'd4,  3'd5,  3'd5,  3'd6,  3'd0,  3'd1,  3'd7};

  initial begin
    st = '{0, 0, 0, 0, 0, 0, 0};
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 3'd2, 1'b0);
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 3'd2, 1'b0);
    drive(1'b0, 1'b1, 8'hFF, 8'hFF, 3'd2, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b1, dir_a[i], dir_b[i], dir_op[i], 1'b0);
    drive(1'b0, 1'b1, 8'd10, 8'd20, 3'd2, 1'b0);
    drive(1'b0, 1'b1, 8'h3C, 8'h0F, 3'd0, 1'b0);
    drive(1'b0, 1'b0, 8'h55, 8'h55, 3'd1, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 3'd6, 1'b0);
    drive(1'b0, 1'b1, 8'd100, 8'd100, 3'd2, 1'b0);
    drive(1'b1, 1'b1, 8'd100, 8'd100, 3'd2, 1'b0);
    drive(1'b0, 1'b0, 8'd1, 8'd1, 3'd2, 1'b0);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom),
            3'($urandom), ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
